// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Carry-pipelined adder/subtractor. The WIDTH-bit operation is split into
//   STAGES chunks of CHUNK = WIDTH/STAGES bits; chunk k is added in stage k
//   by CHUNK/4 four-bit carry-lookahead groups. The carry out of each chunk
//   is registered and consumed by the next stage. Upper operand chunks
//   travel with the operation (skew) and finished lower result chunks are
//   carried forward (deskew), so the whole result leaves together after
//   STAGES cycles. WIDTH must be a multiple of 4*STAGES.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands valid            in_ready  operation accepted this cycle
//   a, b       operands                  cin       carry in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result valid              out_ready downstream accepts result
//   sum        result (mod 2^WIDTH)      cout      carry out of MSB (sub: 1 = no borrow)
//   ovf        signed overflow           zero      sum == 0
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK  = WIDTH / STAGES;
    localparam int GROUPS = CHUNK / 4;

    // Returns {carry_out, sum} of one chunk. Carries inside each 4-bit group
    // are fully expanded lookahead terms; group carries chain through the
    // group generate/propagate pair.
    function automatic logic [CHUNK:0] cla_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] c;
        logic [GROUPS:0]  gc;
        logic [3:0]       gg;
        logic [3:0]       gp;
        logic             grp_g;
        logic             grp_p;
        g     = x & y;
        p     = x ^ y;
        c     = '0;
        gc    = '0;
        gc[0] = ci;
        for (int unsigned j = 0; j < GROUPS; j++) begin
            gg = g[4*j +: 4];
            gp = p[4*j +: 4];
            c[4*j]   = gc[j];
            c[4*j+1] = gg[0] | (gp[0] & gc[j]);
            c[4*j+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[j]);
            c[4*j+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                     | (gp[2] & gp[1] & gp[0] & gc[j]);
            grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0]);
            grp_p = &gp;
            gc[j+1] = grp_g | (grp_p & gc[j]);
        end
        return {gc[GROUPS], p ^ c};
    endfunction

    // Single global advance: the whole pipe moves or the whole pipe holds.
    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_b_eff  = sub ? ~b : b;
    assign w_c0     = sub ? 1'b1 : cin;

    // Intermediate ranks 0..STAGES-2. Rank k registers the finished low
    // (k+1)*CHUNK result bits, the chunk carry and the untouched upper
    // operand bits (realigned to bit 0).
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_pipe
        localparam int LOW = (k + 1) * CHUNK;
        localparam int UPW = WIDTH - LOW;

        logic [CHUNK-1:0] w_x;
        logic [CHUNK-1:0] w_y;
        logic             w_ci;
        logic             w_vin;
        logic [UPW-1:0]   w_a_up;
        logic [UPW-1:0]   w_b_up;
        logic [LOW-1:0]   w_res;
        logic [CHUNK:0]   w_add;

        logic             r_vld;
        logic             r_cy;
        logic [UPW-1:0]   r_a;
        logic [UPW-1:0]   r_b;
        logic [LOW-1:0]   r_res;

        if (k == 0) begin : g_src
            assign w_x    = a[CHUNK-1:0];
            assign w_y    = w_b_eff[CHUNK-1:0];
            assign w_ci   = w_c0;
            assign w_vin  = in_valid;
            assign w_a_up = a[WIDTH-1:CHUNK];
            assign w_b_up = w_b_eff[WIDTH-1:CHUNK];
            assign w_res  = w_add[CHUNK-1:0];
        end else begin : g_src
            assign w_x    = g_pipe[k-1].r_a[CHUNK-1:0];
            assign w_y    = g_pipe[k-1].r_b[CHUNK-1:0];
            assign w_ci   = g_pipe[k-1].r_cy;
            assign w_vin  = g_pipe[k-1].r_vld;
            assign w_a_up = g_pipe[k-1].r_a[UPW+CHUNK-1:CHUNK];
            assign w_b_up = g_pipe[k-1].r_b[UPW+CHUNK-1:CHUNK];
            assign w_res  = {w_add[CHUNK-1:0], g_pipe[k-1].r_res};
        end

        assign w_add = cla_chunk(w_x, w_y, w_ci);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
                r_res <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_cy  <= w_add[CHUNK];
                r_a   <= w_a_up;
                r_b   <= w_b_up;
                r_res <= w_res;
            end
        end
    end

    // Last stage: top chunk plus flags, registered straight into the outputs.
    logic [CHUNK-1:0] w_lx;
    logic [CHUNK-1:0] w_ly;
    logic             w_lci;
    logic             w_lvin;
    logic [CHUNK:0]   w_ladd;
    logic [WIDTH-1:0] w_fsum;
    logic             w_msb_cin;

    if (STAGES == 1) begin : g_last
        assign w_lx   = a;
        assign w_ly   = w_b_eff;
        assign w_lci  = w_c0;
        assign w_lvin = in_valid;
        assign w_fsum = w_ladd[CHUNK-1:0];
    end else begin : g_last
        assign w_lx   = g_pipe[STAGES-2].r_a;
        assign w_ly   = g_pipe[STAGES-2].r_b;
        assign w_lci  = g_pipe[STAGES-2].r_cy;
        assign w_lvin = g_pipe[STAGES-2].r_vld;
        assign w_fsum = {w_ladd[CHUNK-1:0], g_pipe[STAGES-2].r_res};
    end

    assign w_ladd    = cla_chunk(w_lx, w_ly, w_lci);
    // Carry into the MSB recovered from the MSB sum bit: s = x ^ y ^ c.
    assign w_msb_cin = w_ladd[CHUNK-1] ^ w_lx[CHUNK-1] ^ w_ly[CHUNK-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (w_adv) begin
            out_valid <= w_lvin;
            // Bubbles leave the last result and flags untouched.
            if (w_lvin) begin
                sum  <= w_fsum;
                cout <= w_ladd[CHUNK];
                ovf  <= w_msb_cin ^ w_ladd[CHUNK];
                zero <= ~|w_fsum;
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, carry-pipelined adder/subtractor built from 4-bit carry-lookahead groups.
- Splits a WIDTH-bit operation into STAGES chunks, one chunk per pipeline stage, with the inter-chunk carry registered between stages.
- Valid/ready handshake on both sides, full backpressure, one result per cycle at steady state.
- Datapath arithmetic block feeding the ALU/accumulator path where single-cycle ripple across 32+ bits fails timing.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of 4*STAGES.
- STAGES, 4, number of pipeline stages and chunks; CHUNK = WIDTH/STAGES bits per stage; latency = STAGES cycles.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for subtraction, 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits, out_valid, sum, cout, ovf and zero are cleared to 0 immediately. in_ready is 1 one cycle after deassertion. In-flight operations are discarded; no partial result ever appears.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational). Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- When adv=0, every stage register holds, including the valid bits, sum and flags. When adv=1, every stage shifts by one; an empty slot is inserted as a bubble (valid=0).
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using CHUNK/4 four-bit CLA groups. Each group produces generate/propagate signals; group carries are resolved by lookahead within the chunk. Chunk carry-in is the registered carry from stage k-1; stage 0 takes cin, or 1 when sub=1.
- Operand skew: upper chunks of a and b (b already inverted if sub) are delayed in skew registers so that chunk k is added in stage k. Lower result chunks are delayed so that all chunks exit together.
- Latency: a result accepted at edge t is presented with out_valid=1 after edge t+STAGES-1 and is visible from cycle t+STAGES, provided there are no stalls. Each stall cycle adds one cycle.
- Throughput: 1 per cycle when out_ready is held at 1. Back-to-back inputs never collide.
- Flags are computed in the last stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
- Output stability: while out_valid=1 and out_ready=0, sum, cout, ovf and zero are held constant.
- Simultaneous input and output transfer in the same cycle is legal and required at full rate.
- Wrap-around: the result is modulo 2^WIDTH. The carry is reported only on cout.
- When out_valid=0, sum and the flags hold their last value and are don't-care to the consumer.

Test Plan:
- Reset/latency (WIDTH=32, STAGES=4): after reset, out_valid=0 and in_ready=1. Drive a=5, b=7, cin=0, sub=0 for one cycle with out_ready=1 → out_valid=1 exactly 4 cycles later with sum=12, cout=0, ovf=0, zero=0.
- Carry across every chunk: a=0xFFFFFFFF, b=0, cin=1 → sum=0, cout=1, zero=1, ovf=0. Then a=0x7FFFFFFF, b=1 → sum=0x80000000, ovf=1, cout=0.
- Subtract: a=3, b=5, sub=1, cin=1 (cin is ignored) → sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then a=5, b=5, sub=1 → sum=0, zero=1, cout=1.
- Streaming with backpressure: issue 10 back-to-back random operations. Hold out_ready=0 for 3 cycles mid-stream → in_ready drops while out_valid=1; outputs stay stable; all 10 results arrive in order and match the reference model; none are lost or duplicated.
- Bubbles: alternate in_valid 1/0 with out_ready=1 → out_valid follows the same pattern delayed by 4 cycles.
- Reset mid-operation: load 3 operations, assert reset_n low asynchronously mid-cycle → out_valid=0 immediately; after release no stale results appear; a new operation completes with latency 4.
